// File: rtl/fibo_stream_monitor.sv
// Checks an 8-bit Fibonacci term stream against its recurrence and tags each term.
// Tagged terms are buffered in a small FIFO that drains through a valid/ready port.
module fibo_stream_monitor #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] err_count,
  output logic             drop_sticky
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = CNT_W + 3 + DW;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_TRACK} state_t;

  state_t           state_reg;
  logic [DW-1:0]    p1_reg, p2_reg;
  logic [CNT_W-1:0] idx_reg, err_reg;
  logic             drop_reg;

  logic [DW:0]      sum;
  logic             wrap, mismatch, seed_err;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    rd_data_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg;
  logic             out_valid_reg;
  logic             full, push, pop, avail_next;

  // Flags come from the p1/p2 registers before this term updates them.
  always_comb begin
    sum      = {1'b0, p1_reg} + {1'b0, p2_reg};
    wrap     = 1'b0;
    mismatch = 1'b0;
    seed_err = 1'b0;
    case (state_reg)
      S_IDLE:  seed_err = (in_data != '0);
      S_ONE:   seed_err = (in_data != DW'(1));
      default: begin
        mismatch = (in_data != sum[DW-1:0]);
        wrap     = sum[DW];
      end
    endcase
  end

  assign full        = (count_reg == (AW+1)'(DEPTH));
  assign pop         = out_valid_reg & out_ready;
  assign push        = in_valid & ~clr & (~full | pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  // Entries written this edge are not yet readable, so they are excluded here.
  assign avail_next  = (count_reg - (AW+1)'(pop)) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      p1_reg    <= '0;
      p2_reg    <= '0;
      idx_reg   <= '0;
      err_reg   <= '0;
      drop_reg  <= 1'b0;
    end else if (clr) begin
      state_reg <= S_IDLE;
      p1_reg    <= '0;
      p2_reg    <= '0;
      idx_reg   <= '0;
      err_reg   <= '0;
      drop_reg  <= 1'b0;
    end else if (in_valid) begin
      // The checker always follows received values, dropped terms included.
      p1_reg  <= in_data;
      p2_reg  <= p1_reg;
      idx_reg <= idx_reg + 1'b1;
      if ((mismatch || seed_err) && (err_reg != '1))
        err_reg <= err_reg + 1'b1;
      if (full && !pop)
        drop_reg <= 1'b1;
      case (state_reg)
        S_IDLE:  state_reg <= S_ONE;
        default: state_reg <= S_TRACK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg    <= rd_ptr_next;
      out_valid_reg <= avail_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage and registered head read stay reset-free so they map onto RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {idx_reg, wrap, mismatch, seed_err, in_data};
    rd_data_reg <= mem[rd_ptr_next];
  end

  assign out_valid = out_valid_reg;
  assign {out_idx, out_flags, out_data} = out_valid_reg ? rd_data_reg : '0;
  assign err_count   = err_reg;
  assign drop_sticky = drop_reg;

endmodule

// File: tb/tb_fibo_stream_monitor.sv
// Directed-vector bench for fibo_stream_monitor with hand-computed expectations.
`timescale 1ns/1ps
module tb_fibo_stream_monitor;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data, out_idx, err_count;
  logic [2:0] out_flags;
  logic       drop_sticky;

  int n_vec = 0;
  int n_bad = 0;

  int vin   [16];
  int vflag [16];

  fibo_stream_monitor #(.DW(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_flags(out_flags),
    .err_count(err_count), .drop_sticky(drop_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  // Feeds vin[0..n-1] back to back with out_ready=1; term i shows up one edge after its push.
  task automatic run_stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        in_valid = 1'b1; in_data = 8'(vin[i]);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("valid[%0d]", i-1), int'(out_valid), 1);
        chk($sformatf("data[%0d]",  i-1), int'(out_data),  vin[i-1]);
        chk($sformatf("idx[%0d]",   i-1), int'(out_idx),   i-1);
        chk($sformatf("flags[%0d]", i-1), int'(out_flags), vflag[i-1]);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  int'(out_data), 0);
    chk("rst_idx",   int'(out_idx), 0);
    chk("rst_flags", int'(out_flags), 0);
    chk("rst_err",   int'(err_count), 0);
    chk("rst_drop",  int'(drop_sticky), 0);
    rst = 1'b0;
    tick();

    // Clean sequence through the 8-bit wrap: 377->121, 354->98.
    vin = '{0,1,1,2,3,5,8,13,21,34,55,89,144,233,121,98};
    vflag = '{default: 0};
    vflag[14] = 3'b100; vflag[15] = 3'b100;
    run_stream(16);
    chk("clean_err", int'(err_count), 0);
    tick();

    // One corrupted term (5->6) poisons itself and the next two.
    do_clr();
    vin = '{0,1,1,2,3,6,8,13,0,0,0,0,0,0,0,0};
    vflag = '{default: 0};
    vflag[5] = 3'b010; vflag[6] = 3'b010; vflag[7] = 3'b010;
    run_stream(8);
    chk("corrupt_err", int'(err_count), 3);
    tick();

    // Stream starting at 1,1,2.
    do_clr();
    chk("clr_err", int'(err_count), 0);
    vin = '{1,1,2,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vflag = '{default: 0};
    vflag[0] = 3'b001;
    run_stream(3);
    chk("seed_err_cnt", int'(err_count), 1);
    tick();

    // Back-pressure: 6 pushes into a 4-deep FIFO.
    do_clr();
    out_ready = 1'b0;
    vin = '{0,1,1,2,3,5,8,0,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(vin[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("bp_drop",  int'(drop_sticky), 1);
    chk("bp_err",   int'(err_count), 0);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_hold_idx", int'(out_idx), 0);
    tick();
    chk("bp_hold_idx2", int'(out_idx), 0);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("bp_idx[%0d]", k), int'(out_idx), k);
      chk($sformatf("bp_data[%0d]", k), int'(out_data), vin[k]);
    end
    tick();
    chk("bp_empty", int'(out_valid), 0);
    in_valid = 1'b1; in_data = 8'd8;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_next_idx",   int'(out_idx), 6);
    chk("bp_next_flags", int'(out_flags), 0);
    chk("bp_drop_keep",  int'(drop_sticky), 1);
    tick();

    // clr coincident with a term: term ignored, checker restarts expecting 0.
    in_valid = 1'b1; in_data = 8'd7; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("clrv_valid", int'(out_valid), 0);
    chk("clrv_err",   int'(err_count), 0);
    chk("clrv_drop",  int'(drop_sticky), 0);
    vin = '{0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vflag = '{default: 0};
    run_stream(3);
    chk("clrv_err2", int'(err_count), 0);

    // Asynchronous reset mid-stream clears immediately.
    in_valid = 1'b1; in_data = 8'd2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_idx",   int'(out_idx), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
